pc_gen: RTL and testbench

Parametrised program-counter generator for the IF stage. It holds the fetch PC and selects the next PC from sequential, branch, jump and return sources. A return-address stack (RAS) serves call/return, and a run/step/halt state machine lets the debug unit single-step or freeze fetch. It sits between the hazard unit, the ID-stage branch/jump resolution and instruction memory.

---
 rtl/pc_gen.sv | 116 +++++++++++
 tb/tb_pc_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch program counter with sequential/branch/jump/return selection, a circular
// return-address stack, and a run/step/halt control FSM for the debug unit.
module pc_gen #(
    parameter int                     PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0,
    parameter int                     INSTR_BYTES  = 4,
    parameter int                     RAS_DEPTH    = 4
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_enable,
    input  logic                i_pc_write,
    input  logic                i_step_mode,
    input  logic                i_step,
    input  logic                i_halt,
    input  logic                i_branch_taken,
    input  logic [PC_WIDTH-1:0] i_branch_target,
    input  logic                i_jump,
    input  logic [PC_WIDTH-1:0] i_jump_target,
    input  logic                i_call,
    input  logic                i_ret,
    input  logic [PC_WIDTH-1:0] i_link_addr,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic [PC_WIDTH-1:0] o_pc_plus,
    output logic                o_halted,
    output logic                o_ras_empty,
    output logic                o_ras_full,
    output logic                o_ras_ovf,
    output logic                o_ras_unf
);
    localparam int PW = $clog2(RAS_DEPTH);

    typedef enum logic [1:0] {S_RUN, S_STEP, S_HALTED} state_t;

    state_t                             state;
    logic [RAS_DEPTH-1:0][PC_WIDTH-1:0] ras;
    logic [PW-1:0]                      ptr, ptr_m1;
    logic [PW:0]                        count;
    logic                               step_q;

    logic                               step_rise, allow, adv, ras_has, jmp_go;
    logic                               do_push, do_pop, do_swap, unf_evt;
    logic [PC_WIDTH-1:0]                next_pc, ras_top;

    assign step_rise = i_step & ~step_q;
    assign allow     = (state == S_RUN) || ((state == S_STEP) && step_rise);
    assign adv       = i_enable & i_pc_write & allow;
    assign ras_has   = (count != '0);
    assign ptr_m1    = ptr - PW'(1);
    assign ras_top   = ras[ptr_m1];

    // Branch outranks jump, so RAS activity needs a non-halting, non-branch jump.
    assign jmp_go  = adv & ~i_halt & ~i_branch_taken & i_jump;
    assign do_push = jmp_go & i_call & ~i_ret;
    assign do_pop  = jmp_go & i_ret & ~i_call & ras_has;
    assign do_swap = jmp_go & i_ret & i_call & ras_has;
    assign unf_evt = jmp_go & i_ret & ~ras_has;

    always_comb begin
        next_pc = o_pc + PC_WIDTH'(INSTR_BYTES);
        if (i_branch_taken)
            next_pc = i_branch_target;
        else if (i_jump && i_ret)
            next_pc = ras_has ? ras_top : i_jump_target;
        else if (i_jump)
            next_pc = i_jump_target;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= S_RUN;
            o_pc      <= RESET_VECTOR;
            ras       <= '0;
            ptr       <= '0;
            count     <= '0;
            step_q    <= 1'b0;
            o_ras_ovf <= 1'b0;
            o_ras_unf <= 1'b0;
        end else begin
            step_q <= i_step;

            if (adv && i_halt)
                state <= S_HALTED;
            else if (state != S_HALTED)
                state <= i_step_mode ? S_STEP : S_RUN;

            if (adv && !i_halt)
                o_pc <= next_pc;

            // A push into a full stack overwrites the oldest entry: the pointer
            // still advances, only the count saturates.
            if (do_push) begin
                ras[ptr] <= i_link_addr;
                ptr      <= ptr + PW'(1);
                if (count == (PW+1)'(RAS_DEPTH))
                    o_ras_ovf <= 1'b1;
                else
                    count <= count + (PW+1)'(1);
            end
            if (do_pop) begin
                ptr   <= ptr_m1;
                count <= count - (PW+1)'(1);
            end
            if (do_swap)
                ras[ptr_m1] <= i_link_addr;
            if (unf_evt)
                o_ras_unf <= 1'b1;
        end
    end

    assign o_pc_plus   = o_pc + PC_WIDTH'(INSTR_BYTES);
    assign o_halted    = (state == S_HALTED);
    assign o_ras_empty = (count == '0);
    assign o_ras_full  = (count == (PW+1)'(RAS_DEPTH));

endmodule

// File: tb/tb_pc_gen.sv
// Directed test-plan sequences followed by random traffic, all checked against a
// queue-based behavioural model of the PC generator.
module tb_pc_gen;
    localparam int D = 4;

    logic        i_clk = 1'b0, i_reset_n = 1'b0;
    logic        i_enable, i_pc_write, i_step_mode, i_step, i_halt;
    logic        i_branch_taken, i_jump, i_call, i_ret;
    logic [31:0] i_branch_target, i_jump_target, i_link_addr;
    logic [31:0] o_pc, o_pc_plus;
    logic        o_halted, o_ras_empty, o_ras_full, o_ras_ovf, o_ras_unf;

    pc_gen #(.PC_WIDTH(32), .RESET_VECTOR(32'h0), .INSTR_BYTES(4), .RAS_DEPTH(D)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_pc_write(i_pc_write),
        .i_step_mode(i_step_mode), .i_step(i_step), .i_halt(i_halt),
        .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
        .i_jump(i_jump), .i_jump_target(i_jump_target), .i_call(i_call), .i_ret(i_ret),
        .i_link_addr(i_link_addr), .o_pc(o_pc), .o_pc_plus(o_pc_plus), .o_halted(o_halted),
        .o_ras_empty(o_ras_empty), .o_ras_full(o_ras_full), .o_ras_ovf(o_ras_ovf),
        .o_ras_unf(o_ras_unf)
    );

    always #5 i_clk = ~i_clk;

    int n_tot = 0, n_bad = 0;

    // Reference model: mode 0=run 1=step 2=halted, RAS as a bounded queue.
    logic [31:0] m_pc;
    int          m_mode;
    logic        m_step_q, m_ovf, m_unf;
    logic [31:0] m_ras[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_mode = 0; m_step_q = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_step();
        logic        adv;
        logic [31:0] tgt;
        adv = i_enable && i_pc_write &&
              (m_mode == 0 || (m_mode == 1 && i_step && !m_step_q));
        m_step_q = i_step;
        if (adv && i_halt) begin
            m_mode = 2;
        end else begin
            if (adv) begin
                if (i_branch_taken) begin
                    m_pc = i_branch_target;
                end else if (i_jump && i_ret) begin
                    if (m_ras.size() > 0) begin
                        tgt = m_ras[m_ras.size()-1];
                        if (i_call) m_ras[m_ras.size()-1] = i_link_addr;
                        else        void'(m_ras.pop_back());
                    end else begin
                        tgt = i_jump_target;
                        m_unf = 1'b1;
                    end
                    m_pc = tgt;
                end else if (i_jump) begin
                    if (i_call) begin
                        if (m_ras.size() == D) begin
                            void'(m_ras.pop_front());
                            m_ovf = 1'b1;
                        end
                        m_ras.push_back(i_link_addr);
                    end
                    m_pc = i_jump_target;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
            if (m_mode != 2) m_mode = i_step_mode ? 1 : 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    o_pc, m_pc);
        chk({tag, ".plus"},  o_pc_plus, m_pc + 32'd4);
        chk({tag, ".halt"},  32'(o_halted), 32'(m_mode == 2));
        chk({tag, ".flags"}, {28'h0, o_ras_empty, o_ras_full, o_ras_ovf, o_ras_unf},
            {28'h0, m_ras.size() == 0, m_ras.size() == D, m_ovf, m_unf});
    endtask

    // Inputs are set by the caller at posedge+1; model advances, then sample after the edge.
    task automatic tick(input string tag);
        model_step();
        @(posedge i_clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        i_enable = 1; i_pc_write = 1; i_step_mode = 0; i_step = 0; i_halt = 0;
        i_branch_taken = 0; i_jump = 0; i_call = 0; i_ret = 0;
        i_branch_target = 0; i_jump_target = 0; i_link_addr = 0;
    endtask

    task automatic do_reset();
        #3 i_reset_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        #2 i_reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] pc0;
        idle();
        model_reset();
        #2;
        check_all("por");
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;

        // Free run then stall.
        for (int i = 0; i < 3; i++) tick("run");
        chk("run_c", o_pc, 32'hC);
        i_pc_write = 0;
        tick("stall"); tick("stall");
        chk("stall_c", o_pc, 32'hC);
        i_pc_write = 1;

        // Branch beats jump.
        i_branch_taken = 1; i_branch_target = 32'h100; i_jump = 1; i_jump_target = 32'h200;
        i_call = 1; i_link_addr = 32'h77;
        tick("brjmp");
        chk("brjmp_pc", o_pc, 32'h100);
        chk("brjmp_ras", 32'(o_ras_empty), 32'h1);
        idle();

        // Five calls overflow a 4-deep stack, five returns drain it and underflow.
        i_jump = 1; i_call = 1; i_jump_target = 32'h300;
        for (int i = 1; i <= 5; i++) begin
            i_link_addr = 32'(i * 16);
            tick("call");
        end
        chk("call_full", {30'h0, o_ras_full, o_ras_ovf}, 32'h3);
        i_call = 0; i_ret = 1; i_jump_target = 32'h999;
        for (int i = 5; i >= 1; i--) begin
            tick("ret");
            chk("ret_tgt", o_pc, (i > 1) ? 32'(i * 16) : 32'h999);
        end
        chk("ret_unf", 32'(o_ras_unf), 32'h1);
        idle();

        // Step mode: held-high step gives one advance, a fresh rise gives another.
        i_step_mode = 1;
        tick("smode");
        pc0 = o_pc;
        i_step = 1;
        for (int i = 0; i < 5; i++) tick("shold");
        chk("step_one", o_pc, pc0 + 32'd4);
        i_step = 0; tick("slow");
        i_step = 1; tick("srise");
        chk("step_two", o_pc, pc0 + 32'd8);
        i_step = 0; i_step_mode = 0;
        tick("sexit");

        // Halt at 0x40, then asynchronous reset out of it.
        i_jump = 1; i_jump_target = 32'h40;
        tick("to40");
        i_jump = 0; i_halt = 1;
        tick("halt");
        i_halt = 0;
        for (int i = 0; i < 10; i++) tick("halted");
        chk("halt_pc", o_pc, 32'h40);
        chk("halt_flag", 32'(o_halted), 32'h1);
        do_reset();
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_halt", 32'(o_halted), 32'h0);

        // Sequential wrap.
        i_jump = 1; i_jump_target = 32'hFFFF_FFFC;
        tick("tofffc");
        i_jump = 0;
        tick("wrap");
        chk("wrap_pc", o_pc, 32'h0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            i_enable        = ($urandom_range(0, 9) != 0);
            i_pc_write      = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) i_step_mode = ~i_step_mode;
            i_step          = $urandom_range(0, 1);
            i_halt          = ($urandom_range(0, 59) == 0);
            i_branch_taken  = ($urandom_range(0, 5) == 0);
            i_jump          = ($urandom_range(0, 2) == 0);
            i_call          = $urandom_range(0, 1);
            i_ret           = $urandom_range(0, 1);
            i_branch_target = $urandom & 32'hFFFF_FFFC;
            i_jump_target   = $urandom & 32'hFFFF_FFFC;
            i_link_addr     = $urandom & 32'hFFFF_FFFC;
            tick("rnd");
            if (m_mode == 2 && $urandom_range(0, 3) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
